alu_writeback: RTL and testbench

//  Result stage directly downstream of the 16-bit ALU. Takes one ALU result
//  per valid/ready handshake and writes it to the register-file write port.
//  A 32-bit result ({yhigh,y}) takes two write cycles: y to rd, then yhigh to rd+1.

---
 rtl/alu_writeback.sv | 126 ++++++++++++
 tb/tb_alu_writeback.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Result stage behind the 16-bit ALU: captures one result per handshake and writes
// it to the register file (two writes for 32-bit results), and holds {N,V,Z,C}.
module alu_writeback #(
    parameter int N          = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_y,
    input  logic [N-1:0]          in_yhigh,
    input  logic                  in_co,
    input  logic                  in_zero,
    input  logic                  in_overflow,
    input  logic                  in_negative,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wide,
    input  logic                  in_write_reg,
    input  logic                  in_set_flags,
    input  logic                  wb_hold,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [N-1:0]          rf_wdata,
    output logic [3:0]            flags,
    output logic [3:0]            flags_fwd,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR_LO = 2'd1;
    localparam logic [1:0] S_WR_HI = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [N-1:0]          y_q, yhigh_q;
    logic [3:0]            res_flags_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  wide_q, write_reg_q, set_flags_q;
    logic [3:0]            flags_q, flags_d;
    logic                  accept;

    // A wide op cannot take a new result while its low half is still on the port.
    assign in_ready = rst_n && !wb_hold && !((state_q == S_WR_LO) && wide_q);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        if (!wb_hold) begin
            case (state_q)
                S_IDLE: begin
                    state_d = accept ? S_WR_LO : S_IDLE;
                end
                S_WR_LO: begin
                    if (set_flags_q) begin
                        flags_d = res_flags_q;
                    end
                    if (wide_q) begin
                        state_d = S_WR_HI;
                    end else begin
                        state_d = accept ? S_WR_LO : S_IDLE;
                    end
                end
                S_WR_HI: begin
                    state_d = accept ? S_WR_LO : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flags_q     <= 4'b0000;
            y_q         <= '0;
            yhigh_q     <= '0;
            res_flags_q <= 4'b0000;
            rd_q        <= '0;
            wide_q      <= 1'b0;
            write_reg_q <= 1'b0;
            set_flags_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (accept) begin
                y_q         <= in_y;
                yhigh_q     <= in_yhigh;
                res_flags_q <= {in_negative, in_overflow, in_zero, in_co};
                rd_q        <= in_rd;
                wide_q      <= in_wide;
                write_reg_q <= in_write_reg;
                set_flags_q <= in_set_flags;
            end
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state_q)
            S_WR_LO: begin
                rf_we    = write_reg_q && !wb_hold;
                rf_waddr = rd_q;
                rf_wdata = y_q;
            end
            S_WR_HI: begin
                rf_we    = write_reg_q && !wb_hold;
                rf_waddr = rd_q + 1'b1;
                rf_wdata = yhigh_q;
            end
            default: begin
                rf_we    = 1'b0;
            end
        endcase
    end

    // Forwarding lets a dependent ADC see the carry before it is architectural.
    assign flags     = flags_q;
    assign flags_fwd = ((state_q == S_WR_LO) && set_flags_q) ? res_flags_q : flags_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios then random traffic, all checked
// against a queue-of-pending-writes model of the stage.
module tb_alu_writeback;
    localparam int N  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready;
    logic [N-1:0]  in_y, in_yhigh;
    logic          in_co, in_zero, in_overflow, in_negative;
    logic [AW-1:0] in_rd;
    logic          in_wide, in_write_reg, in_set_flags, wb_hold;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic [3:0]    flags, flags_fwd;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    alu_writeback #(.N(N), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_yhigh(in_yhigh), .in_co(in_co), .in_zero(in_zero),
        .in_overflow(in_overflow), .in_negative(in_negative), .in_rd(in_rd),
        .in_wide(in_wide), .in_write_reg(in_write_reg), .in_set_flags(in_set_flags),
        .wb_hold(wb_hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags(flags), .flags_fwd(flags_fwd), .busy(busy)
    );

    // Each accepted result becomes one (narrow) or two (wide) port slots.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
        logic          lo;
        logic          setf;
        logic [3:0]    fl;
    } slot_t;

    slot_t      pend[$];
    logic [3:0] flags_m = 4'b0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic hold, input logic wide,
                         input logic wr, input logic sf, input logic [AW-1:0] rd,
                         input logic [N-1:0] y, input logic [N-1:0] yh, input logic [3:0] fb);
        rst_n        = rst;
        in_valid     = v;
        wb_hold      = hold;
        in_wide      = wide;
        in_write_reg = wr;
        in_set_flags = sf;
        in_rd        = rd;
        in_y         = y;
        in_yhigh     = yh;
        {in_negative, in_overflow, in_zero, in_co} = fb;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 4'b0000);
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle();
        logic          e_we, e_busy, e_rdy;
        logic [AW-1:0] e_addr;
        logic [N-1:0]  e_data;
        logic [3:0]    e_fwd;
        #1;
        e_rdy = rst_n && !wb_hold && (pend.size() < 2);
        if (pend.size() == 0) begin
            e_we = 1'b0; e_addr = '0; e_data = '0; e_fwd = flags_m; e_busy = 1'b0;
        end else begin
            e_we   = pend[0].we && !wb_hold;
            e_addr = pend[0].addr;
            e_data = pend[0].data;
            e_fwd  = (pend[0].lo && pend[0].setf) ? pend[0].fl : flags_m;
            e_busy = 1'b1;
        end
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
        chk("rf_wdata", 32'(rf_wdata), 32'(e_data));
        chk("flags", 32'(flags), 32'(flags_m));
        chk("flags_fwd", 32'(flags_fwd), 32'(e_fwd));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic finish_cycle();
        logic          acc;
        slot_t         s;
        logic [AW-1:0] hi_addr;
        @(posedge clk);
        if (!rst_n) begin
            pend.delete();
            flags_m = 4'b0000;
        end else if (!wb_hold) begin
            acc = in_valid && (pend.size() < 2);
            if (pend.size() > 0) begin
                s = pend.pop_front();
                if (s.lo && s.setf) flags_m = s.fl;
            end
            if (acc) begin
                n_txn++;
                $display("txn %0d: rd=%0d wide=%0b wr=%0b sf=%0b y=%h yh=%h nvzc=%b",
                         n_txn, in_rd, in_wide, in_write_reg, in_set_flags, in_y, in_yhigh,
                         {in_negative, in_overflow, in_zero, in_co});
                s.we = in_write_reg; s.addr = in_rd; s.data = in_y; s.lo = 1'b1;
                s.setf = in_set_flags; s.fl = {in_negative, in_overflow, in_zero, in_co};
                pend.push_back(s);
                if (in_wide) begin
                    hi_addr = in_rd + 3'd1;
                    s.addr = hi_addr; s.data = in_yhigh; s.lo = 1'b0; s.setf = 1'b0;
                    pend.push_back(s);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 4'b0000);
        @(negedge clk);
        settle(); chk("rst_ready_low", 32'(in_ready), 32'd0); finish_cycle();
        settle(); finish_cycle();

        // 1: narrow op with carry
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1234, 16'h0000, 4'b0001);
        settle(); chk("t1_after_reset_busy", 32'(busy), 32'd0); finish_cycle();
        idle(); settle();
        chk("t1_we", 32'(rf_we), 32'd1);
        chk("t1_waddr", 32'(rf_waddr), 32'd3);
        chk("t1_wdata", 32'(rf_wdata), 32'h1234);
        finish_cycle();
        settle();
        chk("t1_flags", 32'(flags), 32'b0001);
        chk("t1_busy", 32'(busy), 32'd0);
        finish_cycle();

        // 2: wide op wrapping rd+1, valid held high
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 16'hBEEF, 16'hDEAD, 4'b0000);
        settle(); finish_cycle();
        settle();
        chk("t2_lo_ready", 32'(in_ready), 32'd0);
        chk("t2_lo_addr", 32'(rf_waddr), 32'd7);
        chk("t2_lo_data", 32'(rf_wdata), 32'hBEEF);
        finish_cycle();
        settle();
        chk("t2_hi_addr", 32'(rf_waddr), 32'd0);
        chk("t2_hi_data", 32'(rf_wdata), 32'hDEAD);
        finish_cycle();
        idle();
        for (int i = 0; i < 3; i++) begin settle(); finish_cycle(); end

        // 3: three back-to-back narrow writes
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(i + 1), 16'(16'h0A00 + i), '0, 4'b0000);
            else idle();
            settle();
            if (i < 3) chk("t3_ready", 32'(in_ready), 32'd1);
            if (i >= 1 && i <= 3) begin
                chk("t3_we", 32'(rf_we), 32'd1);
                chk("t3_waddr", 32'(rf_waddr), 32'(i));
            end
            finish_cycle();
        end

        // 4: carry forwarding from ADD to following ADC
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, '0, '0, 4'b0000);
        settle(); finish_cycle();
        idle(); settle(); finish_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0001, '0, 4'b0001);
        settle(); finish_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0002, '0, 4'b0000);
        settle();
        chk("t4_fwd_c", 32'(flags_fwd[0]), 32'd1);
        chk("t4_flags_c", 32'(flags[0]), 32'd0);
        finish_cycle();
        idle(); settle(); finish_cycle();

        // 5: hold for three cycles during WR_LO
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'h5555, '0, 4'b1010);
        settle(); finish_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 16'h6666, '0, 4'b0000);
            settle();
            chk("t5_hold_we", 32'(rf_we), 32'd0);
            chk("t5_hold_ready", 32'(in_ready), 32'd0);
            chk("t5_hold_flags", 32'(flags), 32'b0001);
            finish_cycle();
        end
        idle(); settle();
        chk("t5_we", 32'(rf_we), 32'd1);
        chk("t5_wdata", 32'(rf_wdata), 32'h5555);
        finish_cycle();
        settle(); chk("t5_flags", 32'(flags), 32'b1010); finish_cycle();

        // 6: reset during WR_LO of a wide op
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h1111, 16'h2222, 4'b1111);
        settle(); finish_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 4'b0000);
        settle(); finish_cycle();
        idle(); settle();
        chk("t6_we", 32'(rf_we), 32'd0);
        chk("t6_flags", 32'(flags), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        finish_cycle();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 70),
                  ($urandom_range(0, 99) < 15), 1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            settle();
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
